fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of the decoder/control_unit pair. Holds the architectural fetch PC, issues word requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words with their PCs in a 2-entry FIFO, and presents them to the decoder with valid/ready. Consumes control_unit's `j_signal`/`jump` redirect: it flushes the buffer, discards any in-flight response and refetches from the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset; must be word-aligned.
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `j_signal`  in  1  redirect request from control_unit, sampled every cycle
- `jump`  in  32  redirect target, valid when `j_signal`=1
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address (word-aligned)
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid, in order, ≥1 cycle after grant
- `imem_rdata`  in  32  response instruction word
- `instr_valid`  out  1  FIFO head valid toward decoder
- `instr_ready`  in  1  decoder accepts head
- `instr`  out  32  FIFO head instruction
- `pc_out`  out  32  PC of FIFO head
- `fetch_fault`  out  1  sticky misaligned-redirect flag

## Operation
- State registers: `fetch_pc`, `req_pc` (PC of outstanding request), FIFO (2 entries × {pc,instr}, count 0..2), `fault`, FSM {IDLE, WAIT, DROP}. At most one outstanding request.
- IDLE: no outstanding request. WAIT: one outstanding, data kept. DROP: one outstanding, data discarded.
- `pop` = `instr_valid && instr_ready`. `fill` = state WAIT && `imem_rvalid`. `occ` = count − pop + fill.
- `imem_req` = rst high && !`fault` && !`j_signal` && (IDLE || fill) && `occ` < 2. Combinational from `imem_rvalid`, `instr_ready` and `j_signal`.
- `imem_addr` = `fetch_pc`. On `imem_req && imem_gnt`: `req_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc`+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), next state WAIT.
- Ungranted request: state unchanged (or IDLE if leaving WAIT via fill). `imem_req`/`imem_addr` are held until granted or redirected.
- WAIT with `imem_rvalid` and no redirect: push {`req_pc`,`imem_rdata`}. Next state WAIT if a new grant happens the same cycle, otherwise IDLE.
- DROP with `imem_rvalid`: discard data, go to IDLE. `imem_rvalid` in IDLE is ignored.
- `instr_valid` = count≠0 && !`j_signal`. `instr`/`pc_out` always show the head entry, 0 when empty.
- Redirect (`j_signal`=1):
  - FIFO count ← 0; no pop counted.
  - `fetch_pc` ← `jump`.
  - WAIT without `imem_rvalid` goes to DROP. WAIT with `imem_rvalid` discards the data and goes to IDLE. DROP stays DROP unless `imem_rvalid`, then IDLE.
- `jump[1:0]`≠0 on redirect: `fault` ← 1 and all of the above applies. While `fault`=1, no requests are issued.
- A later redirect with an aligned target clears `fault`. Reset also clears it. `fetch_fault` = `fault`.

## Timing
- Reset (async assert): state IDLE, count 0, `fetch_pc`=`RESET_PC`, `req_pc`=0, FIFO entries 0, `fault`=0.
- Outputs during reset: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `pc_out`=0, `fetch_fault`=0.
- First cycle after `rst` deasserts: `imem_req`=1 with `imem_addr`=`RESET_PC`.
- Latency: grant in cycle N, `imem_rvalid` in cycle M≥N+1, `instr_valid` from cycle M+1.
- With a 1-cycle memory and a continuously ready consumer: one instruction per cycle after the first.
- Redirect in cycle N: `imem_req`=0 in N. `imem_req`=1 with `imem_addr`=`jump` in N+1 if the state is IDLE at N+1; otherwise it waits for the DROP response.
- Reset asserted mid-operation aborts everything immediately. Memory responses for requests issued before reset are the environment's responsibility.

## Test plan
- Reset release, 1-cycle memory with rdata=addr^0xA5A5_0000, `instr_ready`=1 → grants to 0x0, 0x4, 0x8 on consecutive cycles; `pc_out` 0x0, 0x4, 0x8 each paired with the matching rdata; `instr_valid` continuous from the 3rd cycle.
- `instr_ready`=0 for 5 cycles → count reaches 2 and `imem_req` drops. With no pop, the FIFO holds 0x0/0x4. Raise ready → 0x0 then 0x4 delivered, fetching resumes at 0x8, no loss or duplication.
- Redirect `jump`=0x100 while a request is outstanding and rvalid is 2 cycles late → `instr_valid`=0 in the redirect cycle. The stale response is dropped. The next request is addr 0x100 after the stale rvalid, and the first delivered `pc_out`=0x100.
- Redirect in the same cycle as `imem_rvalid` → that data is discarded and `imem_req` to the target is issued the next cycle.
- Redirect `jump`=0x102 → `fetch_fault`=1, `imem_req` stays 0 for 10 cycles. Redirect 0x200 → fault clears and a fetch from 0x200 begins.
- `RESET_PC`=0xFFFF_FFF8 → fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Assert `rst` mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, keeps at most one imem request
// outstanding, buffers returned words with their PCs, and flushes on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        j_signal,
  input  logic [31:0] jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        fetch_fault
);

  // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response discarded
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        fault;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic [1:0]  count;

  logic        pop;
  logic        fill;
  logic        grant;
  logic [2:0]  occ;
  logic        wr_idx;

  assign pop    = instr_valid && instr_ready;
  assign fill   = (state_q == WAIT) && imem_rvalid;
  assign occ    = {1'b0, count} - {2'b00, pop} + {2'b00, fill};
  // Slot the returning word lands in, after this cycle's pop has shifted the head.
  assign wr_idx = (count == 2'd2) || ((count == 2'd1) && !pop);

  assign imem_req    = rst && !fault && !j_signal &&
                       ((state_q == IDLE) || fill) && (occ < 3'd2);
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;

  assign instr_valid = (count != 2'd0) && !j_signal;
  assign instr       = (count != 2'd0) ? fifo_instr[0] : 32'h0;
  assign pc_out      = (count != 2'd0) ? fifo_pc[0]    : 32'h0;
  assign fetch_fault = fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d takes its default before any branch so no path leaves it unassigned.
    state_d = state_q;
    if (j_signal) begin
      if ((state_q != IDLE) && imem_rvalid) state_d = IDLE;
      else if (state_q == WAIT)             state_d = DROP;
    end else if (grant) begin
      state_d = WAIT;
    end else if ((state_q != IDLE) && imem_rvalid) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0;
      fault    <= 1'b0;
    end else if (j_signal) begin
      fetch_pc <= jump;
      fault    <= |jump[1:0];
    end else if (grant) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      // NOTE: only two entries, so they are reset to keep the head defined from the first cycle.
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= 32'h0;
        fifo_instr[i] <= 32'h0;
      end
    end else if (j_signal) begin
      count <= 2'd0;
    end else begin
      if (pop) begin
        fifo_pc[0]    <= fifo_pc[1];
        fifo_instr[0] <= fifo_instr[1];
      end
      // NOTE: if pop and fill both target entry 0, this later non-blocking write wins.
      if (fill) begin
        fifo_pc[wr_idx]    <= req_pc;
        fifo_instr[wr_idx] <= imem_rdata;
      end
      count <= occ[1:0];
    end
  end

endmodule
